alu_arbiter: RTL and testbench
==============================

Name:
alu_arbiter

Overview:
- Shares a single combinational ALU datapath (W-bit operands, OPW-bit opcode) between two requesters.
- Round-robin arbitration, valid/ready handshake on the request and response sides.
- Operands and opcode are registered into the ALU, and the result is captured after a fixed ALU_LAT cycles.
- Sits between the ALU instance and the blocks issuing operations to it.

Parameters:
- W, 9: operand/result width.
- OPW, 4: opcode width.
- ALU_LAT, 1: cycles from ALU operand launch to a valid alu_y. Legal range is 1..15.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  2  bit i = requester i has an operation pending.
- req_ready  output  2  bit i = operation from requester i accepted this cycle; one-hot or zero.
- req_a  input  2*W  operand A; requester i in bits [i*W +: W].
- req_b  input  2*W  operand B; same packing as req_a.
- req_op  input  2*OPW  opcode; requester i in bits [i*OPW +: OPW].
- alu_a  output  W  registered operand A to the ALU.
- alu_b  output  W  registered operand B to the ALU.
- alu_op  output  OPW  registered opcode to the ALU.
- alu_y  input  W  ALU result.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  index of the requester that owns the response.
- rsp_data  output  W  captured ALU result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE, prio=0, cnt=0.
  - alu_a, alu_b, alu_op, rsp_data, rsp_id all 0.
  - rsp_valid=0, busy=0, req_ready=0.
  - An in-flight operation is dropped with no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant selection: if both requests are valid, grant = prio. Otherwise grant = the single valid requester.
  - req_ready[grant] is asserted combinationally in the same cycle. Acceptance is valid & ready at the clock edge.
  - On the accept edge:
    - alu_a/alu_b/alu_op <= granted slice.
    - rsp_id <= grant.
    - cnt <= ALU_LAT-1.
    - go to WAIT.
  - If no request is valid, stay in IDLE.
- WAIT:
  - req_ready=0.
  - If cnt==0: rsp_data <= alu_y, go to RESP. Otherwise cnt <= cnt-1.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - On the edge with rsp_ready=1: go to IDLE, prio <= ~rsp_id (the other requester now has priority).
  - No new request is accepted in the same cycle as response acceptance. The earliest next accept is the first IDLE cycle.
- Latency:
  - Accept edge at T -> rsp_valid high after edge T+ALU_LAT.
  - Minimum request-to-request spacing is ALU_LAT+2 cycles with rsp_ready tied high.
- Operand stability: alu_a/alu_b/alu_op hold their last values outside WAIT. They do not change until the next accept.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- Starvation bound: a valid requester is served within two operations.
- Requester rule: a requester must not drop req_valid or change its slice until accepted. The block does not check this rule.
- rsp_ready held low: the block stays in RESP indefinitely. req_ready stays 0 and no request is lost.
- Width: no arithmetic is performed on data. cnt is 4 bits.

Test Plan:
- Reset values: rst pulsed mid-WAIT -> all outputs 0 immediately (async), state IDLE; first grant after release goes to requester 0 when both are valid.
- Single requester: req_valid=01, a=9'h005, b=9'h003, op=4'h1, ALU adds -> req_ready=01 for one cycle; rsp_valid after ALU_LAT edges, rsp_data=9'h008, rsp_id=0.
- Contention: req_valid=11 held for 4 operations with rsp_ready=1 -> rsp_id sequence 0,1,0,1; each response carries the matching requester's result.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, rsp_data/rsp_id stable, req_ready=00, busy=1; after rsp_ready=1, IDLE then next accept.
- Latency parameter: ALU_LAT=3 -> rsp_valid rises exactly 3 edges after the accept edge; alu_a/alu_b stable throughout WAIT.
- Max-width data: a=b=9'h1FF through requester 1 -> alu_a=alu_b=9'h1FF, rsp_data equals alu_y exactly, with no truncation.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU. The result is captured ALU_LAT
// cycles after launch and held as a valid/ready response.
module alu_arbiter #(
    parameter int W       = 9,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*W-1:0]   req_a,
    input  logic [2*W-1:0]   req_b,
    input  logic [2*OPW-1:0] req_op,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [W-1:0]     alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_prio;
    logic [3:0]       r_cnt;
    logic [W-1:0]     r_alu_a;
    logic [W-1:0]     r_alu_b;
    logic [OPW-1:0]   r_alu_op;
    logic [W-1:0]     r_rsp_data;
    logic             r_rsp_id;
    logic             w_grant;
    logic             w_accept;

    // Grant: priority pointer breaks ties, otherwise the lone valid requester wins.
    always_comb begin
        w_grant   = (&req_valid) ? r_prio : req_valid[1];
        w_accept  = (r_state == IDLE) && (|req_valid);
        req_ready = '0;
        if (w_accept && !rst)
            req_ready = w_grant ? 2'b10 : 2'b01;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|req_valid) w_next = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand launch, latency countdown, result capture and priority update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio     <= 1'b0;
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_a  <= w_grant ? req_a[2*W-1:W]       : req_a[W-1:0];
                        r_alu_b  <= w_grant ? req_b[2*W-1:W]       : req_b[W-1:0];
                        r_alu_op <= w_grant ? req_op[2*OPW-1:OPW]  : req_op[OPW-1:0];
                        r_rsp_id <= w_grant;
                        r_cnt    <= LAT_M1;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0)
                        r_rsp_data <= alu_y;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                RESP: begin
                    if (rsp_ready)
                        r_prio <= ~r_rsp_id;
                end
                default: ;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3.
module tb_alu_arbiter;

    localparam int W   = 9;
    localparam int OPW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance with ALU_LAT=1
    logic [1:0]       rv1, rr1;
    logic [2*W-1:0]   ra1, rb1;
    logic [2*OPW-1:0] rop1;
    logic [W-1:0]     aa1, ab1, ay1, data1;
    logic [OPW-1:0]   aop1;
    logic             vld1, rsp_rdy1, id1, busy1;

    // Instance with ALU_LAT=3
    logic [1:0]       rv3, rr3;
    logic [2*W-1:0]   ra3, rb3;
    logic [2*OPW-1:0] rop3;
    logic [W-1:0]     aa3, ab3, ay3, data3;
    logic [OPW-1:0]   aop3;
    logic             vld3, rsp_rdy3, id3, busy3;

    alu_arbiter #(.W(W), .OPW(OPW), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1),
        .req_a(ra1), .req_b(rb1), .req_op(rop1),
        .alu_a(aa1), .alu_b(ab1), .alu_op(aop1), .alu_y(ay1),
        .rsp_valid(vld1), .rsp_ready(rsp_rdy1), .rsp_id(id1),
        .rsp_data(data1), .busy(busy1)
    );

    alu_arbiter #(.W(W), .OPW(OPW), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3),
        .req_a(ra3), .req_b(rb3), .req_op(rop3),
        .alu_a(aa3), .alu_b(ab3), .alu_op(aop3), .alu_y(ay3),
        .rsp_valid(vld3), .rsp_ready(rsp_rdy3), .rsp_id(id3),
        .rsp_data(data3), .busy(busy3)
    );

    // Reference ALU: 0 AND, 1 ADD, 2 SUB, 3 XOR
    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OPW-1:0] op);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h3:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign ay1 = alu_f(aa1, ab1, aop1);
    assign ay3 = alu_f(aa3, ab3, aop3);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]     valid;
        logic [W-1:0]   a0, b0;
        logic [OPW-1:0] op0;
        logic [W-1:0]   a1, b1;
        logic [OPW-1:0] op1;
        logic [1:0]     exp_rdy;
        logic           exp_id;
        logic [W-1:0]   exp_data;
        logic [W-1:0]   exp_alu_a;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  steps;
        bit  got;
        bit  stable_ok;

        tbl[0] = '{2'b01, 9'h005, 9'h003, 4'h1, 9'h000, 9'h000, 4'h0, 2'b01, 1'b0, 9'h008, 9'h005};
        tbl[1] = '{2'b10, 9'h000, 9'h000, 4'h0, 9'h1FF, 9'h1FF, 4'h0, 2'b10, 1'b1, 9'h1FF, 9'h1FF};
        tbl[2] = '{2'b11, 9'h00A, 9'h004, 4'h2, 9'h007, 9'h002, 4'h1, 2'b01, 1'b0, 9'h006, 9'h00A};
        tbl[3] = '{2'b11, 9'h0F0, 9'h0FF, 4'h3, 9'h007, 9'h002, 4'h1, 2'b10, 1'b1, 9'h009, 9'h007};
        tbl[4] = '{2'b11, 9'h0F0, 9'h0FF, 4'h3, 9'h100, 9'h0AA, 4'h1, 2'b01, 1'b0, 9'h00F, 9'h0F0};
        tbl[5] = '{2'b11, 9'h003, 9'h005, 4'h2, 9'h100, 9'h0AA, 4'h1, 2'b10, 1'b1, 9'h1AA, 9'h100};
        tbl[6] = '{2'b10, 9'h000, 9'h000, 4'h0, 9'h123, 9'h0F0, 4'h0, 2'b10, 1'b1, 9'h020, 9'h123};

        rv1 = '0; ra1 = '0; rb1 = '0; rop1 = '0; rsp_rdy1 = 1'b1;
        rv3 = '0; ra3 = '0; rb3 = '0; rop3 = '0; rsp_rdy3 = 1'b1;

        // Reset values
        #1;
        chk("rst_alu_a", aa1, 0);
        chk("rst_rsp_valid", vld1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_rsp_data", data1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table-driven operations on the ALU_LAT=1 instance
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rv1  = tbl[i].valid;
            ra1  = {tbl[i].a1, tbl[i].a0};
            rb1  = {tbl[i].b1, tbl[i].b0};
            rop1 = {tbl[i].op1, tbl[i].op0};
            rsp_rdy1 = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", i), rr1, tbl[i].exp_rdy);
            steps = 0; got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                steps++;
                if (vld1) got = 1'b1;
            end
            chk($sformatf("v%0d_rsp_seen", i), got, 1);
            chk($sformatf("v%0d_latency", i), steps, 2);
            chk($sformatf("v%0d_rsp_id", i), id1, tbl[i].exp_id);
            chk($sformatf("v%0d_rsp_data", i), data1, tbl[i].exp_data);
            chk($sformatf("v%0d_alu_a", i), aa1, tbl[i].exp_alu_a);
        end
        @(negedge clk);
        rv1 = '0;

        // Backpressure: response held while a new request waits
        @(negedge clk);
        rv1  = 2'b11;
        ra1  = {9'h002, 9'h011};
        rb1  = {9'h002, 9'h022};
        rop1 = {4'h1, 4'h1};
        rsp_rdy1 = 1'b0;
        #1;
        chk("bp_ready", rr1, 2'b01);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (vld1) got = 1'b1;
        end
        chk("bp_rsp_seen", got, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", vld1, 1);
            chk("bp_hold_data", data1, 9'h033);
            chk("bp_hold_id", id1, 0);
            chk("bp_hold_ready", rr1, 2'b00);
            chk("bp_hold_busy", busy1, 1);
        end
        rsp_rdy1 = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_idle_valid", vld1, 0);
        chk("bp_idle_busy", busy1, 0);
        chk("bp_next_ready", rr1, 2'b10);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (vld1) got = 1'b1;
        end
        chk("bp_next_seen", got, 1);
        chk("bp_next_id", id1, 1);
        chk("bp_next_data", data1, 9'h004);
        @(negedge clk);
        rv1 = '0;

        // ALU_LAT=3: exact response latency and operand stability in WAIT
        @(negedge clk);
        rv3  = 2'b01;
        ra3  = {9'h000, 9'h0AB};
        rb3  = {9'h000, 9'h011};
        rop3 = {4'h0, 4'h1};
        rsp_rdy3 = 1'b1;
        #1;
        chk("lat3_ready", rr3, 2'b01);
        steps = 0; got = 1'b0; stable_ok = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            steps++;
            if (vld3) got = 1'b1;
            else if (aa3 !== 9'h0AB || ab3 !== 9'h011 || busy3 !== 1'b1) stable_ok = 1'b0;
        end
        chk("lat3_rsp_seen", got, 1);
        chk("lat3_latency", steps, 4);
        chk("lat3_stable", stable_ok, 1);
        chk("lat3_rsp_data", data3, 9'h0BC);
        chk("lat3_rsp_id", id3, 0);
        @(negedge clk);
        rv3 = '0;

        // Asynchronous reset in the middle of WAIT drops the operation
        @(negedge clk);
        rv3  = 2'b10;
        ra3  = {9'h055, 9'h00C};
        rb3  = {9'h011, 9'h003};
        rop3 = {4'h1, 4'h2};
        #1;
        chk("rstw_ready", rr3, 2'b10);
        @(negedge clk);
        chk("rstw_busy_before", busy3, 1);
        rv3 = 2'b11;
        rst = 1'b1;
        #1;
        chk("rstw_alu_a", aa3, 0);
        chk("rstw_alu_b", ab3, 0);
        chk("rstw_alu_op", aop3, 0);
        chk("rstw_rsp_data", data3, 0);
        chk("rstw_rsp_id", id3, 0);
        chk("rstw_rsp_valid", vld3, 0);
        chk("rstw_busy", busy3, 0);
        chk("rstw_req_ready", rr3, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstw_first_grant", rr3, 2'b01);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (vld3) got = 1'b1;
        end
        chk("rstw_rsp_seen", got, 1);
        chk("rstw_post_id", id3, 0);
        chk("rstw_post_data", data3, 9'h009);
        @(negedge clk);
        rv3 = '0;

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
